// File: rtl/ifft4_stage_seq.sv
// ----------------------------------------------------------------------------
// ifft4_stage_seq
//   Sequential inverse radix-2 stage of the 4-point FFT datapath.
//   Collects one frame of four complex samples (a, b, c, d) over a
//   valid/ready stream. It applies the conjugate twiddles W4^0* = 1 and
//   W4^1* = +j (Q.TW_FRAC) and forms the butterflies:
//     y0 = A + C,  y1 = B + D,  y2 = A - C,  y3 = B - D.
//   Each result is floor-shifted right by OUT_SHIFT and truncated to DATA_W.
//   The four results stream out in order.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input sample valid
//   in_ready   block can accept a sample (registered)
//   in_sop     input sample is index 0 (a) of a frame
//   in_re      input real part, signed DATA_W
//   in_im      input imaginary part, signed DATA_W
//   out_valid  output sample valid
//   out_ready  downstream accepts output
//   out_last   output sample is index 3 of the frame
//   out_re     output real part, signed DATA_W
//   out_im     output imaginary part, signed DATA_W
//   out_ovf    shifted value of the current output did not fit DATA_W
//   frame_err  one-cycle pulse: in_sop seen mid-frame, frame restarted
// ----------------------------------------------------------------------------
module ifft4_stage_seq #(
    parameter int DATA_W    = 64,
    parameter int TW_FRAC   = 7,
    parameter int OUT_SHIFT = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sop,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_ovf,
    output logic                     frame_err
);

    // Internal width: the product of a sample with the twiddle, plus the
    // butterfly add, plus one guard bit.
    localparam int W = DATA_W + TW_FRAC + 2;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN
    } state_t;

    state_t                   state;
    logic [1:0]               cnt;
    logic [1:0]               ocnt;
    logic signed [DATA_W-1:0] buf_re [4];
    logic signed [DATA_W-1:0] buf_im [4];
    logic signed [DATA_W-1:0] res_re [4];
    logic signed [DATA_W-1:0] res_im [4];
    logic [3:0]               res_ovf;

    logic signed [W-1:0]      a_re, a_im, b_re, b_im;
    logic signed [W-1:0]      c_re, c_im, d_re, d_im;
    logic signed [W-1:0]      y_re [4];
    logic signed [W-1:0]      y_im [4];
    logic signed [DATA_W-1:0] nxt_re [4];
    logic signed [DATA_W-1:0] nxt_im [4];
    logic [3:0]               nxt_ovf;

    logic                     in_acc;
    logic                     out_acc;

    // Sign-extend to W bits and multiply by the unit twiddle 2**TW_FRAC.
    function automatic logic signed [W-1:0] scale(input logic signed [DATA_W-1:0] x);
        logic signed [W-1:0] e;
        e = {{(W - DATA_W){x[DATA_W-1]}}, x};
        return e <<< TW_FRAC;
    endfunction

    // Floor the value (arithmetic shift), then keep the low DATA_W bits.
    function automatic logic signed [DATA_W-1:0] shr(input logic signed [W-1:0] y);
        logic signed [W-1:0] s;
        s = y >>> OUT_SHIFT;
        return s[DATA_W-1:0];
    endfunction

    // Flag values whose shifted result lies outside the signed DATA_W range.
    // The upper bits must all copy the DATA_W sign bit.
    function automatic logic ovf(input logic signed [W-1:0] y);
        logic signed [W-1:0] s;
        s = y >>> OUT_SHIFT;
        return !((&s[W-1:DATA_W-1]) || !(|s[W-1:DATA_W-1]));
    endfunction

    assign in_acc  = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;

    always_comb begin
        a_re = scale(buf_re[0]);
        a_im = scale(buf_im[0]);
        b_re = scale(buf_re[1]);
        b_im = scale(buf_im[1]);
        c_re = scale(buf_re[2]);
        c_im = scale(buf_im[2]);
        // Multiplying d by +j swaps the parts and negates the new real part.
        d_re = -scale(buf_im[3]);
        d_im = scale(buf_re[3]);

        y_re[0] = a_re + c_re;
        y_im[0] = a_im + c_im;
        y_re[1] = b_re + d_re;
        y_im[1] = b_im + d_im;
        y_re[2] = a_re - c_re;
        y_im[2] = a_im - c_im;
        y_re[3] = b_re - d_re;
        y_im[3] = b_im - d_im;

        nxt_re[0]  = shr(y_re[0]);
        nxt_im[0]  = shr(y_im[0]);
        nxt_re[1]  = shr(y_re[1]);
        nxt_im[1]  = shr(y_im[1]);
        nxt_re[2]  = shr(y_re[2]);
        nxt_im[2]  = shr(y_im[2]);
        nxt_re[3]  = shr(y_re[3]);
        nxt_im[3]  = shr(y_im[3]);
        nxt_ovf[0] = ovf(y_re[0]) || ovf(y_im[0]);
        nxt_ovf[1] = ovf(y_re[1]) || ovf(y_im[1]);
        nxt_ovf[2] = ovf(y_re[2]) || ovf(y_im[2]);
        nxt_ovf[3] = ovf(y_re[3]) || ovf(y_im[3]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            cnt       <= '0;
            ocnt      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_ovf   <= 1'b0;
            frame_err <= 1'b0;
            res_ovf   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                buf_re[i] <= '0;
                buf_im[i] <= '0;
                res_re[i] <= '0;
                res_im[i] <= '0;
            end
        end else begin
            frame_err <= 1'b0;
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_acc) begin
                        if (in_sop && cnt != 2'd0) begin
                            // A start-of-packet mid-frame restarts the frame
                            // with this sample as index 0.
                            buf_re[0] <= in_re;
                            buf_im[0] <= in_im;
                            cnt       <= 2'd1;
                            frame_err <= 1'b1;
                        end else begin
                            buf_re[cnt] <= in_re;
                            buf_im[cnt] <= in_im;
                            cnt         <= cnt + 2'd1;
                            if (cnt == 2'd3) begin
                                state    <= COMPUTE;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                end

                COMPUTE: begin
                    // y0 goes straight to the output registers. y1..y3 wait
                    // in the result bank.
                    for (int unsigned i = 0; i < 4; i++) begin
                        res_re[i] <= nxt_re[i];
                        res_im[i] <= nxt_im[i];
                    end
                    res_ovf   <= nxt_ovf;
                    out_re    <= nxt_re[0];
                    out_im    <= nxt_im[0];
                    out_ovf   <= nxt_ovf[0];
                    out_last  <= 1'b0;
                    out_valid <= 1'b1;
                    ocnt      <= 2'd0;
                    state     <= DRAIN;
                end

                DRAIN: begin
                    if (out_acc) begin
                        if (ocnt == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            cnt       <= 2'd0;
                            state     <= LOAD;
                        end else begin
                            ocnt     <= ocnt + 2'd1;
                            out_re   <= res_re[ocnt + 2'd1];
                            out_im   <= res_im[ocnt + 2'd1];
                            out_ovf  <= res_ovf[ocnt + 2'd1];
                            out_last <= (ocnt == 2'd2);
                        end
                    end
                end

                default: begin
                    state     <= LOAD;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifft4_stage_seq.sv
// ----------------------------------------------------------------------------
// tb_ifft4_stage_seq
//   Directed bench for ifft4_stage_seq. It uses two instances that share all
//   inputs:
//     dut   default parameters (OUT_SHIFT = 7)
//     dut8  OUT_SHIFT = 8, used for the floor-rounding case
// ----------------------------------------------------------------------------
module tb_ifft4_stage_seq;

    localparam int DW = 64;
    localparam logic signed [DW-1:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_sop;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 out_ready;

    logic                 in_ready, out_valid, out_last, out_ovf, frame_err;
    logic signed [DW-1:0] out_re, out_im;
    logic                 in_ready8, out_valid8, out_last8, out_ovf8, frame_err8;
    logic signed [DW-1:0] out_re8, out_im8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifft4_stage_seq #(.DATA_W(DW), .TW_FRAC(7), .OUT_SHIFT(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_re(out_re), .out_im(out_im), .out_ovf(out_ovf),
        .frame_err(frame_err)
    );

    ifft4_stage_seq #(.DATA_W(DW), .TW_FRAC(7), .OUT_SHIFT(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready8), .in_sop(in_sop),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid8), .out_ready(out_ready), .out_last(out_last8),
        .out_re(out_re8), .out_im(out_im8), .out_ovf(out_ovf8),
        .frame_err(frame_err8)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until it is accepted. The wait is
    // bounded by a cycle budget.
    task automatic send(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                        input logic sop);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_sop   = sop;
        in_re    = re;
        in_im    = im;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    // Wait (bounded) for an output and check it, then let it be accepted.
    // This assumes out_ready is already high.
    task automatic recv(input string tag, input logic signed [DW-1:0] er,
                        input logic signed [DW-1:0] ei, input logic el, input logic eo,
                        input logic chk8, input logic signed [DW-1:0] er8);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_re"}, out_re, er);
        check({tag, "_im"}, out_im, ei);
        check({tag, "_last"}, {63'd0, out_last}, {63'd0, el});
        check({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, eo});
        if (chk8) begin
            check({tag, "_re8"}, out_re8, er8);
            check({tag, "_im8"}, out_im8, 64'd0);
        end
        tick();
    endtask

    initial begin
        logic signed [DW-1:0] er [4];
        logic signed [DW-1:0] ei [4];
        logic                 el [4];
        er = '{64'sd2, -64'sd1, 64'sd0, 64'sd1};
        ei = '{64'sd0, 64'sd1, 64'sd0, 64'sd1};
        el = '{1'b0, 1'b0, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        check("rst_out_re", out_re, 64'd0);
        check("rst_out_im", out_im, 64'd0);
        check("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);
        rst_n = 1'b1;
        check("rel_in_ready_low", {63'd0, in_ready}, 64'd0);
        tick();
        check("rel_in_ready_high", {63'd0, in_ready}, 64'd1);

        // Case 1: basic frame, out_ready held high
        out_ready = 1'b1;
        send(1, 0, 1'b1);
        send(0, 1, 1'b0);
        send(1, 0, 1'b0);
        send(0, 1, 1'b0);
        check("c1_compute_no_valid", {63'd0, out_valid}, 64'd0);
        check("c1_compute_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        check("c1_latency_valid", {63'd0, out_valid}, 64'd1);
        recv("c1_y0", 2, 0, 1'b0, 1'b0, 1'b0, 0);
        recv("c1_y1", -1, 1, 1'b0, 1'b0, 1'b0, 0);
        recv("c1_y2", 0, 0, 1'b0, 1'b0, 1'b0, 0);
        recv("c1_y3", 1, 1, 1'b1, 1'b0, 1'b0, 0);
        check("c1_done_valid", {63'd0, out_valid}, 64'd0);
        check("c1_done_in_ready", {63'd0, in_ready}, 64'd1);

        // Case 2: back-pressure, 3 stalled cycles on every output
        out_ready = 1'b0;
        send(1, 0, 1'b1);
        send(0, 1, 1'b0);
        send(1, 0, 1'b0);
        send(0, 1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                check("c2_hold_valid", {63'd0, out_valid}, 64'd1);
                check("c2_hold_re", out_re, er[i]);
                check("c2_hold_im", out_im, ei[i]);
                check("c2_hold_last", {63'd0, out_last}, {63'd0, el[i]});
                check("c2_in_ready_low", {63'd0, in_ready}, 64'd0);
                tick();
            end
            out_ready = 1'b1;
            check("c2_acc_re", out_re, er[i]);
            check("c2_acc_im", out_im, ei[i]);
            tick();
            out_ready = 1'b0;
        end
        check("c2_done_valid", {63'd0, out_valid}, 64'd0);
        check("c2_done_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;

        // Case 3: resync on a mid-frame in_sop
        send(7, 7, 1'b1);
        send(3, 3, 1'b0);
        check("c3_no_err_yet", {63'd0, frame_err}, 64'd0);
        send(5, 0, 1'b1);
        check("c3_frame_err_pulse", {63'd0, frame_err}, 64'd1);
        send(0, 0, 1'b0);
        check("c3_frame_err_clear", {63'd0, frame_err}, 64'd0);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        recv("c3_y0", 5, 0, 1'b0, 1'b0, 1'b0, 0);
        recv("c3_y1", 0, 0, 1'b0, 1'b0, 1'b0, 0);
        recv("c3_y2", 5, 0, 1'b0, 1'b0, 1'b0, 0);
        recv("c3_y3", 0, 0, 1'b1, 1'b0, 1'b0, 0);

        // Case 4: floor rounding (the OUT_SHIFT = 8 instance)
        send(-1, 0, 1'b1);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        send(0, 0, 1'b0);
        recv("c4_y0", -1, 0, 1'b0, 1'b0, 1'b1, -1);
        recv("c4_y1", 0, 0, 1'b0, 1'b0, 1'b1, 0);
        recv("c4_y2", -1, 0, 1'b0, 1'b0, 1'b1, -1);
        recv("c4_y3", 0, 0, 1'b1, 1'b0, 1'b1, 0);

        // Case 5: overflow wraps y0 to 2**64-2 (= -2), ovf on y0 only
        send(MAXV, 0, 1'b1);
        send(0, 0, 1'b0);
        send(MAXV, 0, 1'b0);
        send(0, 0, 1'b0);
        recv("c5_y0", -2, 0, 1'b0, 1'b1, 1'b0, 0);
        recv("c5_y1", 0, 0, 1'b0, 1'b0, 1'b0, 0);
        recv("c5_y2", 0, 0, 1'b0, 1'b0, 1'b0, 0);
        recv("c5_y3", 0, 0, 1'b1, 1'b0, 1'b0, 0);

        // Case 6: asynchronous reset during DRAIN after y1
        send(1, 0, 1'b1);
        send(0, 1, 1'b0);
        send(1, 0, 1'b0);
        send(0, 1, 1'b0);
        recv("c6_y0", 2, 0, 1'b0, 1'b0, 1'b0, 0);
        recv("c6_y1", -1, 1, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("c6_rst_valid", {63'd0, out_valid}, 64'd0);
        check("c6_rst_re", out_re, 64'd0);
        check("c6_rst_im", out_im, 64'd0);
        check("c6_rst_last", {63'd0, out_last}, 64'd0);
        check("c6_rst_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("c6_rel_in_ready", {63'd0, in_ready}, 64'd1);
        check("c6_rel_valid", {63'd0, out_valid}, 64'd0);
        send(1, 0, 1'b1);
        send(0, 1, 1'b0);
        send(1, 0, 1'b0);
        send(0, 1, 1'b0);
        recv("c6n_y0", 2, 0, 1'b0, 1'b0, 1'b0, 0);
        recv("c6n_y1", -1, 1, 1'b0, 1'b0, 1'b0, 0);
        recv("c6n_y2", 0, 0, 1'b0, 1'b0, 1'b0, 0);
        recv("c6n_y3", 1, 1, 1'b1, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
